clz_share_ctrl: RTL and testbench
=================================

Name: clz_share_ctrl

Overview:
- Sequencing and arbitration controller that shares one combinational leading-zero counter (existing my_clz, 32-bit in, 32-bit count out) between two requesters.
- Requester 0 is the ALU CLZ/CLO path; requester 1 is a secondary user such as a normalization step.
- Supports CLZ and CLO operations. Each request is accepted, computed and returned through a three-state FSM with a one-cycle done pulse to the granted requester.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration between requesters; 0 = fixed priority, requester 0 always wins.
- WIDTH, 32, operand/result width; fixed at 32 to match my_clz, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0_i  input  1  requester 0 request; hold with stable op/data until done0_o
- op0_i  input  1  requester 0 op: 0 = CLZ, 1 = CLO
- data0_i  input  32  requester 0 operand
- req1_i  input  1  requester 1 request
- op1_i  input  1  requester 1 op
- data1_i  input  32  requester 1 operand
- done0_o  output  1  one-cycle pulse: result_o valid for requester 0
- done1_o  output  1  one-cycle pulse: result_o valid for requester 1
- result_o  output  32  count, 0..32
- busy_o  output  1  high while in CALC or RESP

Behaviour:
- One clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE, done0_o/done1_o = 0, result_o = 0, busy_o = 0, last_grant = 1 (requester 0 preferred first).
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise arbitrate and latch operand into op_q. For CLO, latch ~data; for CLZ, latch data.
  - Latch grant id into gid_q, then go to CALC.
- Arbitration when both requests are high:
  - RR_EN = 1: grant the requester not equal to last_grant.
  - RR_EN = 0: grant requester 0.
  - A single request is always granted.
- CALC:
  - op_q drives my_clz. Register its count into result_o.
  - Go to RESP.
- RESP:
  - Assert done{gid_q}_o for exactly this cycle. The other done stays 0.
  - last_grant <= gid_q. Go to IDLE.
  - Requests are not sampled in RESP.
- Latency and throughput:
  - A request seen in IDLE at cycle T produces done at T+2.
  - Maximum throughput is one operation per 3 cycles.
- Requester must drop req in the cycle after done. If still high in IDLE, it is treated as a new request.
- result_o holds its last value until the next CALC update. It is not cleared on IDLE.
- Request withdrawn or data changed during CALC/RESP: ignored. The latched operation completes and done still pulses.
- Boundary results:
  - CLZ(0) = 32, CLZ(0x80000000) = 0, CLZ(1) = 31.
  - CLO(0xFFFFFFFF) = 32, CLO(0) = 0.
- Reset mid-operation (CALC or RESP): abort with no done pulse. Next cycle all outputs are at reset values.
- done0_o and done1_o are never high simultaneously.
- busy_o = (state != IDLE), registered with the state.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2; 2'd3 is illegal and recovers to IDLE.
  - Op encoding: OP_CLZ = 1'b0, OP_CLO = 1'b1.
  - Constant CLZ_MAX = 32.
- One sub-module: the existing my_clz instance, driven by op_q. No other hierarchy; arbiter and FSM are local.

Test Plan:
- Reset, then req0_i = 1, op0_i = 0, data0_i = 0x00010000 at cycle T -> busy_o high T+1..T+2; done0_o pulses at T+2 with result_o = 15; done1_o stays 0.
- req1_i CLO 0xFF000000 -> result 8. CLZ 0x00000000 -> 32. CLO 0xFFFFFFFF -> 32. CLZ 0x80000000 -> 0.
- RR_EN = 1, req0_i and req1_i held high continuously after reset -> done order 0,1,0,1,... with one done every 3 cycles.
- RR_EN = 0, both requests held high -> done0_o every 3 cycles, done1_o never.
- req0_i CLZ 0x0000000F, req0_i dropped and data changed during CALC -> done0_o still pulses at T+2 with result_o = 28.
- rst asserted in CALC -> no done pulse; next cycle result_o = 0 and busy_o = 0. A following req1_i CLZ 0x00000001 completes with result 31, and requester 0 keeps priority on the first contention.

Source files
------------

// File: rtl/clz_share_ctrl_pkg.sv
// Shared encodings and helpers for the CLZ/CLO sharing controller.
// Holds the FSM state and op codes plus the fixed count range of my_clz.
package clz_share_ctrl_pkg;

  localparam int CLZ_WIDTH = 32;
  localparam int CLZ_MAX   = 32;

  // 2'd3 is left unnamed on purpose; the FSM treats it as a fault and returns to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_CLZ = 1'b0,
    OP_CLO = 1'b1
  } op_t;

  // Counting leading ones is counting leading zeros of the inverted word.
  function automatic logic [CLZ_WIDTH-1:0] prep_operand(input op_t op,
                                                        input logic [CLZ_WIDTH-1:0] data);
    return (op == OP_CLO) ? ~data : data;
  endfunction

endpackage

// File: rtl/my_clz.sv
// Combinational 32-bit leading-zero counter; an all-zero input yields CLZ_MAX.
module my_clz
  import clz_share_ctrl_pkg::*;
(
  input  logic [CLZ_WIDTH-1:0] a,
  output logic [CLZ_WIDTH-1:0] cnt
);

  // NOTE: give every always_comb output a value before any condition, otherwise a latch is inferred.
  always_comb begin
    cnt = CLZ_WIDTH'(CLZ_MAX);
    // Scanning upward lets the highest set bit overwrite any lower one.
    for (int i = 0; i < CLZ_WIDTH; i++) begin
      if (a[i]) cnt = CLZ_WIDTH'(CLZ_WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/clz_share_ctrl.sv
// Arbitrates two requesters onto one shared my_clz and sequences IDLE -> CALC -> RESP,
// returning the count with a one-cycle done pulse to the granted requester.
module clz_share_ctrl
  import clz_share_ctrl_pkg::*;
#(
  parameter bit RR_EN = 1'b1,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_i,
  input  logic             op0_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic             req1_i,
  input  logic             op1_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic             done0_o,
  output logic             done1_o,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  state_t           state;
  logic             last_grant;
  logic             gid_q;
  logic [WIDTH-1:0] op_q;

  logic             grant;
  op_t              sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] clz_cnt;

  // Contention goes to whoever was not served last (round robin) or always to requester 0.
  always_comb begin
    grant = 1'b0;
    if (req0_i && req1_i) begin
      grant = RR_EN ? ~last_grant : 1'b0;
    end else if (req1_i) begin
      grant = 1'b1;
    end
  end

  assign sel_op   = grant ? op_t'(op1_i) : op_t'(op0_i);
  assign sel_data = grant ? data1_i : data0_i;

  my_clz u_clz (
    .a   (op_q),
    .cnt (clz_cnt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done0_o    <= 1'b0;
      done1_o    <= 1'b0;
      result_o   <= '0;
      busy_o     <= 1'b0;
      last_grant <= 1'b1;
      gid_q      <= 1'b0;
      // NOTE: op_q is pure datapath, always written before it is consumed, so it carries no reset.
    end else begin
      done0_o <= 1'b0;
      done1_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_i || req1_i) begin
            op_q   <= prep_operand(sel_op, sel_data);
            gid_q  <= grant;
            state  <= CALC;
            busy_o <= 1'b1;
          end
        end
        CALC: begin
          // Done is launched here so it is registered and lines up with the new result in RESP.
          result_o <= clz_cnt;
          done0_o  <= ~gid_q;
          done1_o  <= gid_q;
          state    <= RESP;
          busy_o   <= 1'b1;
        end
        RESP: begin
          last_grant <= gid_q;
          state      <= IDLE;
          busy_o     <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clz_share_ctrl.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share one stimulus stream;
// expected completions are queued at issue time and matched by a monitor on the falling edge.
module tb_clz_share_ctrl;
  import clz_share_ctrl_pkg::*;

  typedef struct {
    logic        id;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, op0, req1, op1;
  logic [31:0] data0, data1;

  logic        rr_done0, rr_done1, rr_busy;
  logic [31:0] rr_result;
  logic        fp_done0, fp_done1, fp_busy;
  logic [31:0] fp_result;

  exp_t sb[2][$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clz_share_ctrl #(.RR_EN(1'b1), .WIDTH(32)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_i(req0), .op0_i(op0), .data0_i(data0),
    .req1_i(req1), .op1_i(op1), .data1_i(data1),
    .done0_o(rr_done0), .done1_o(rr_done1), .result_o(rr_result), .busy_o(rr_busy)
  );

  clz_share_ctrl #(.RR_EN(1'b0), .WIDTH(32)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_i(req0), .op0_i(op0), .data0_i(data0),
    .req1_i(req1), .op1_i(op1), .data1_i(data1),
    .done0_o(fp_done0), .done1_o(fp_done1), .result_o(fp_result), .busy_o(fp_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push(input int k, input logic id, input logic [31:0] res, input int at);
    exp_t e;
    e.id  = id;
    e.res = res;
    e.cyc = at;
    sb[k].push_back(e);
  endtask

  task automatic mon(input int k, input logic d0, input logic d1, input logic [31:0] r);
    exp_t  e;
    string pfx;
    pfx = (k == 0) ? "rr" : "fp";
    if (d0 || d1) begin
      check({pfx, "_done_exclusive"}, {31'b0, d0 & d1}, 32'd0);
      if (sb[k].size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_spurious_done: got done0=%0b done1=%0b expected no done at cycle %0d",
                 pfx, d0, d1, cyc);
      end else begin
        e = sb[k].pop_front();
        check({pfx, "_done_id"}, {31'b0, d1}, {31'b0, e.id});
        check({pfx, "_result"}, r, e.res);
        check({pfx, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, rr_done0, rr_done1, rr_result);
      mon(1, fp_done0, fp_done1, fp_result);
    end
  end

  task automatic check_busy(input string name, input logic exp);
    check({"rr_", name}, {31'b0, rr_busy}, {31'b0, exp});
    check({"fp_", name}, {31'b0, fp_busy}, {31'b0, exp});
  endtask

  task automatic check_reset_state(input string name);
    check({"rr_", name, "_result"}, rr_result, 32'd0);
    check({"fp_", name, "_result"}, fp_result, 32'd0);
    check({"rr_", name, "_done"}, {30'b0, rr_done1, rr_done0}, 32'd0);
    check({"fp_", name, "_done"}, {30'b0, fp_done1, fp_done0}, 32'd0);
    check_busy({name, "_busy"}, 1'b0);
  endtask

  // One request from requester id, dropped after it is sampled; chg also scrambles the inputs
  // while the operation is in flight.
  task automatic single(input logic id, input op_t op, input logic [31:0] data,
                        input logic [31:0] exp, input bit chg);
    int t;
    @(posedge clk); #1;
    if (id) begin req1 = 1'b1; op1 = op; data1 = data; end
    else    begin req0 = 1'b1; op0 = op; data0 = data; end
    t = cyc;
    push(0, id, exp, t + 2);
    push(1, id, exp, t + 2);
    @(negedge clk); check_busy("busy_idle", 1'b0);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    if (chg) begin
      data0 = ~data0; data1 = ~data1; op0 = ~op0; op1 = ~op1;
    end
    @(negedge clk); check_busy("busy_calc", 1'b1);
    @(posedge clk); @(negedge clk); check_busy("busy_resp", 1'b1);
    @(posedge clk); @(negedge clk); check_busy("busy_back_idle", 1'b0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    req0 = 1'b0; op0 = OP_CLZ; data0 = '0;
    req1 = 1'b0; op1 = OP_CLZ; data1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); check_reset_state("after_reset");

    single(1'b0, OP_CLZ, 32'h0001_0000, 32'd15, 1'b0);
    single(1'b1, OP_CLO, 32'hFF00_0000, 32'd8,  1'b0);
    single(1'b0, OP_CLZ, 32'h0000_0000, 32'd32, 1'b0);
    single(1'b1, OP_CLO, 32'hFFFF_FFFF, 32'd32, 1'b0);
    single(1'b0, OP_CLZ, 32'h8000_0000, 32'd0,  1'b0);
    single(1'b1, OP_CLZ, 32'h0000_0001, 32'd31, 1'b0);
    single(1'b0, OP_CLO, 32'h0000_0000, 32'd0,  1'b0);
    single(1'b0, OP_CLZ, 32'h0000_000F, 32'd28, 1'b1);

    // Continuous contention straight out of reset: four back-to-back operations.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req0 = 1'b1; op0 = OP_CLZ; data0 = 32'h00F0_0000;
    req1 = 1'b1; op1 = OP_CLO; data1 = 32'hFFFF_0000;
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      push(0, i[0], i[0] ? 32'd16 : 32'd8, t + 2 + 3 * i);
      push(1, 1'b0, 32'd8, t + 2 + 3 * i);
    end
    repeat (10) @(posedge clk);
    #1 req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(posedge clk);

    // Reset while the request sits in CALC: no done, everything back to reset values.
    @(posedge clk); #1 req0 = 1'b1; op0 = OP_CLZ; data0 = 32'h0000_00FF;
    @(posedge clk); #1 req0 = 1'b0; rst = 1'b1;
    @(negedge clk); check_busy("busy_calc_before_reset", 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); check_reset_state("abort_in_calc");

    single(1'b1, OP_CLZ, 32'h0000_0001, 32'd31, 1'b0);

    // First contention after the requester-1 operation: both instances serve requester 0.
    @(posedge clk); #1;
    req0 = 1'b1; op0 = OP_CLZ; data0 = 32'h0000_0100;
    req1 = 1'b1; op1 = OP_CLO; data1 = 32'hF000_0000;
    push(0, 1'b0, 32'd23, cyc + 2);
    push(1, 1'b0, 32'd23, cyc + 2);
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(posedge clk);

    @(negedge clk);
    check("rr_pending_expectations", 32'(sb[0].size()), 32'd0);
    check("fp_pending_expectations", 32'(sb[1].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
